i2c_scl_gen_param: RTL and testbench
====================================

Name: i2c_scl_gen_param

Overview:
Parametrised I2C master SCL/data-clock generator with clock-stretching support, run/idle control, stretch timeout and period/phase status.
- Divides `clk` into a 4-quarter SCL bit period.
- Holds the period while a slave stretches SCL low.
- Feeds the I2C master byte/bit FSM, which shifts SDA on `data_clk` edges and uses `period_done` to step bits.

Parameters:
- DIVIDER, 70000, clk cycles per quarter SCL period; must be ≥ 2.
- CBITS, 19, quarter-counter width; must satisfy 2^CBITS ≥ 4*DIVIDER.
- TIMEOUT, 1000000, max consecutive stretch cycles before timeout; must be ≥ 1.
- TBITS, 20, timeout-counter width; must satisfy 2^TBITS > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  run request; sampled every cycle.
- scl_in  in  1  SCL line level, already synchronised upstream; 0 = line held low.
- timeout_clr  in  1  clears sticky `timeout`.
- scl_clk  out  1  SCL drive level; 1 = released.
- data_clk  out  1  SDA shift clock.
- phase  out  2  current quarter, 0..3.
- busy  out  1  generator in RUN.
- stretching  out  1  counter frozen by slave stretch this cycle.
- period_done  out  1  one-cycle pulse on period wrap.
- timeout  out  1  sticky: stretch exceeded TIMEOUT.

Behaviour:
- Single clock. Reset is synchronous and active-high. All outputs are registered.
- `rst` has priority over every other input.
- Reset values:
  - cnt = 0, tcnt = 0, state = IDLE.
  - scl_clk = 1, data_clk = 0, phase = 0.
  - busy = 0, stretching = 0, period_done = 0, timeout = 0.
- States:
  - IDLE: cnt held at 0; scl_clk = 1, data_clk = 0, phase = 0, busy = 0.
  - RUN: cnt counts 0..4*DIVIDER-1.
- IDLE→RUN: on a cycle with ena = 1. That cycle cnt stays 0 and outputs take decode(0); busy = 1 from the next edge.
- RUN counter update, each cycle, in priority order:
  - Hold: if phase 2 AND scl_in == 0 AND timeout == 0, cnt holds and stretching = 1.
  - Wrap: else if cnt == 4*DIVIDER-1, cnt → 0 and period_done = 1. If ena == 0 at that cycle, go to IDLE (idle outputs).
  - Count: else cnt → cnt+1.
- `ena` deasserted mid-period has no effect until the wrap. Periods are never truncated.
- Decode of the updated cnt (registered, so outputs reflect the new count at the same edge):
  - cnt < D: phase 0, scl_clk 0, data_clk 0.
  - D ≤ cnt < 2D: phase 1, scl_clk 0, data_clk 1.
  - 2D ≤ cnt < 3D: phase 2, scl_clk 1, data_clk 1.
  - 3D ≤ cnt: phase 3, scl_clk 1, data_clk 0.
- Stretch:
  - Checked every cycle in phase 2, not only at phase entry.
  - cnt resumes on the first cycle scl_in == 1.
  - scl_clk stays 1 (released) while stretching.
- Timeout:
  - tcnt increments each stretching cycle and clears on any non-stretching cycle.
  - When tcnt reaches TIMEOUT-1 while stretching, timeout is set the next edge.
  - While timeout = 1, stretch is ignored and the period continues.
  - timeout_clr clears timeout. If a set and timeout_clr occur in the same cycle, set wins.
- Arithmetic:
  - Comparisons use CBITS-wide unsigned values.
  - cnt never exceeds 4*DIVIDER-1.
  - tcnt saturates and never wraps.
- Reset mid-stretch or mid-period returns to IDLE with reset values. No partial period is completed.

Test Plan:
1. DIVIDER=4, TIMEOUT=8. rst, then ena=1 held, scl_in=1 → 16-cycle period.
   - scl_clk: 0 for 8 cycles, then 1 for 8 cycles.
   - data_clk: pattern 0000 1111 1111 0000.
   - period_done pulses every 16 cycles.
   - phase steps 0, 1, 2, 3.
2. Same setup; drive scl_in=0 for 5 cycles after phase 2 entry:
   - cnt frozen 5 cycles; stretching = 1 for exactly 5 cycles.
   - Period = 21 cycles; timeout stays 0.
3. Same setup; hold scl_in=0 in phase 2:
   - timeout rises after 8 stretching cycles.
   - Counting resumes and that period completes.
   - timeout_clr pulse → timeout = 0.
4. Drop ena at cnt=5:
   - Period runs to cnt=15, period_done pulses, then IDLE with scl_clk=1 and busy=0.
   - Re-raise ena → restart at cnt 0.
5. Assert rst mid-stretch with timeout=1 → all outputs at reset values the next edge.
6. Same-cycle events:
   - timeout set and timeout_clr in the same cycle → timeout = 1.
   - rst and ena both high → IDLE.

Source files
------------

// File: rtl/i2c_scl_gen_param_if.sv
// Bus between the SCL/data-clock generator and the I2C master logic that controls it.
interface i2c_scl_gen_param_if;
  logic       ena;
  logic       scl_in;
  logic       timeout_clr;
  logic       scl_clk;
  logic       data_clk;
  logic [1:0] phase;
  logic       busy;
  logic       stretching;
  logic       period_done;
  logic       timeout;

  modport master (
    output ena, scl_in, timeout_clr,
    input  scl_clk, data_clk, phase, busy, stretching, period_done, timeout
  );

  modport slave (
    input  ena, scl_in, timeout_clr,
    output scl_clk, data_clk, phase, busy, stretching, period_done, timeout
  );
endinterface

// File: rtl/i2c_scl_gen_param.sv
// I2C master SCL/data-clock generator: four-quarter bit period, slave clock stretching
// held in quarter 2, sticky stretch timeout, and registered period/phase status.
module i2c_scl_gen_param #(
  parameter int DIVIDER = 70000,
  parameter int CBITS   = 19,
  parameter int TIMEOUT = 1000000,
  parameter int TBITS   = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  i2c_scl_gen_param_if.slave     bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CBITS-1:0] Q1   = CBITS'(DIVIDER);
  localparam logic [CBITS-1:0] Q2   = CBITS'(2 * DIVIDER);
  localparam logic [CBITS-1:0] Q3   = CBITS'(3 * DIVIDER);
  localparam logic [CBITS-1:0] LAST = CBITS'(4 * DIVIDER - 1);

  localparam logic [TBITS-1:0] T_LAST = TBITS'(TIMEOUT - 1);
  localparam logic [TBITS-1:0] T_MAX  = '1;

  logic [0:0]       r_state;
  logic [CBITS-1:0] r_cnt;
  logic [TBITS-1:0] r_tcnt;
  logic             r_scl_clk;
  logic             r_data_clk;
  logic [1:0]       r_phase;
  logic             r_busy;
  logic             r_stretching;
  logic             r_period_done;
  logic             r_timeout;

  logic             w_hold;
  logic             w_wrap;
  logic [0:0]       w_state_nxt;
  logic [CBITS-1:0] w_cnt_nxt;
  logic [3:0]       w_dec;

  // Returns {phase, scl_clk, data_clk} for a quarter-counter value.
  function automatic logic [3:0] decode(input logic [CBITS-1:0] c);
    if (c < Q1)      decode = 4'b00_0_0;
    else if (c < Q2) decode = 4'b01_0_1;
    else if (c < Q3) decode = 4'b10_1_1;
    else             decode = 4'b11_1_0;
  endfunction

  // A stretch only freezes the count while the timeout has not yet fired.
  assign w_hold = (r_state == S_RUN) && (r_phase == 2'd2) && !bus.scl_in && !r_timeout;
  assign w_wrap = (r_state == S_RUN) && !w_hold && (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == S_IDLE) begin
      w_cnt_nxt = '0;
      if (bus.ena) w_state_nxt = S_RUN;
    end else if (w_hold) begin
      w_cnt_nxt = r_cnt;
    end else if (w_wrap) begin
      w_cnt_nxt = '0;
      if (!bus.ena) w_state_nxt = S_IDLE;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
    w_dec = decode(w_cnt_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_tcnt        <= '0;
      r_scl_clk     <= 1'b1;
      r_data_clk    <= 1'b0;
      r_phase       <= 2'd0;
      r_busy        <= 1'b0;
      r_stretching  <= 1'b0;
      r_period_done <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_busy        <= (w_state_nxt == S_RUN);
      r_stretching  <= w_hold;
      r_period_done <= w_wrap;
      if (w_state_nxt == S_IDLE) begin
        r_phase    <= 2'd0;
        r_scl_clk  <= 1'b1;
        r_data_clk <= 1'b0;
      end else begin
        r_phase    <= w_dec[3:2];
        r_scl_clk  <= w_dec[1];
        r_data_clk <= w_dec[0];
      end
      if (w_hold) begin
        if (r_tcnt != T_MAX) r_tcnt <= r_tcnt + 1'b1;
      end else begin
        r_tcnt <= '0;
      end
      // Setting wins over a simultaneous clear so a fresh timeout is never lost.
      if (w_hold && (r_tcnt == T_LAST)) r_timeout <= 1'b1;
      else if (bus.timeout_clr)         r_timeout <= 1'b0;
    end
  end

  assign bus.scl_clk     = r_scl_clk;
  assign bus.data_clk    = r_data_clk;
  assign bus.phase       = r_phase;
  assign bus.busy        = r_busy;
  assign bus.stretching  = r_stretching;
  assign bus.period_done = r_period_done;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_i2c_scl_gen_param.sv
// Scoreboard bench for i2c_scl_gen_param with DIVIDER=4, TIMEOUT=8 (16-cycle SCL period).
module tb_i2c_scl_gen_param;

  typedef struct packed {
    logic       chk;
    logic       scl;
    logic       dat;
    logic [1:0] ph;
    logic       busy;
    logic       str;
    logic       pd;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  i2c_scl_gen_param_if bus();

  i2c_scl_gen_param #(
    .DIVIDER (4),
    .CBITS   (5),
    .TIMEOUT (8),
    .TBITS   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string nm_q[$];
  int    errors = 0;
  int    checks = 0;

  // Expected outputs in RUN at quarter count k (period of 16 counts).
  function automatic exp_t mk_run(int k, logic s, logic p, logic t);
    exp_t e;
    e.chk  = 1'b1;
    e.scl  = (k >= 8);
    e.dat  = (k >= 4) && (k < 12);
    e.ph   = 2'(k / 4);
    e.busy = 1'b1;
    e.str  = s;
    e.pd   = p;
    e.to   = t;
    return e;
  endfunction

  function automatic exp_t mk_idle(logic p, logic t);
    exp_t e;
    e.chk  = 1'b1;
    e.scl  = 1'b1;
    e.dat  = 1'b0;
    e.ph   = 2'd0;
    e.busy = 1'b0;
    e.str  = 1'b0;
    e.pd   = p;
    e.to   = t;
    return e;
  endfunction

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic step(input logic e_v, input logic s_v, input logic c_v, input logic r_v,
                      input exp_t e, input string nm);
    @(negedge clk);
    rst             = r_v;
    bus.ena         = e_v;
    bus.scl_in      = s_v;
    bus.timeout_clr = c_v;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Monitor: one queued expectation per rising edge.
  initial begin
    exp_t  e;
    exp_t  a;
    string n;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        a = {1'b1, bus.scl_clk, bus.data_clk, bus.phase, bus.busy,
             bus.stretching, bus.period_done, bus.timeout};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got scl=%b dat=%b ph=%0d busy=%b str=%b pd=%b to=%b, expected scl=%b dat=%b ph=%0d busy=%b str=%b pd=%b to=%b",
                   n, a.scl, a.dat, a.ph, a.busy, a.str, a.pd, a.to,
                   e.scl, e.dat, e.ph, e.busy, e.str, e.pd, e.to);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ena         = 1'b0;
    bus.scl_in      = 1'b1;
    bus.timeout_clr = 1'b0;

    // Reset and idle
    step(0, 1, 0, 1, mk_idle(0, 0), "reset0");
    step(0, 1, 0, 1, mk_idle(0, 0), "reset1");
    step(0, 1, 0, 0, mk_idle(0, 0), "idle_no_ena");

    // Free-running periods
    step(1, 1, 0, 0, mk_run(0, 0, 0, 0), "t1_start");
    for (int c = 1; c <= 32; c++)
      step(1, 1, 0, 0, mk_run(c % 16, 0, (c % 16) == 0, 0), $sformatf("t1_c%0d", c));

    // Five-cycle stretch at phase-2 entry
    for (int k = 1; k <= 8; k++) step(1, 1, 0, 0, mk_run(k, 0, 0, 0), $sformatf("t2_k%0d", k));
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, mk_run(8, 1, 0, 0), $sformatf("t2_hold%0d", i));
    for (int k = 9; k <= 16; k++)
      step(1, 1, 0, 0, mk_run(k % 16, 0, k == 16, 0), $sformatf("t2_k%0d", k));

    // Stretch mid phase 2 until timeout, then the period completes
    for (int k = 1; k <= 10; k++) step(1, 1, 0, 0, mk_run(k, 0, 0, 0), $sformatf("t3_k%0d", k));
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 0, mk_run(10, 1, 0, i == 8), $sformatf("t3_hold%0d", i));
    for (int k = 11; k <= 16; k++)
      step(1, 0, 0, 0, mk_run(k % 16, 0, k == 16, 1), $sformatf("t3_resume_k%0d", k));
    step(1, 1, 1, 0, mk_run(1, 0, 0, 0), "t3_clr");

    // Timeout set and clear in the same cycle: set wins
    for (int k = 2; k <= 8; k++) step(1, 1, 0, 0, mk_run(k, 0, 0, 0), $sformatf("t6a_k%0d", k));
    for (int i = 1; i <= 8; i++) step(1, 0, i == 8, 0, mk_run(8, 1, 0, i == 8), $sformatf("t6a_hold%0d", i));
    step(1, 1, 1, 0, mk_run(9, 0, 0, 0), "t6a_clr");
    for (int k = 10; k <= 16; k++)
      step(1, 1, 0, 0, mk_run(k % 16, 0, k == 16, 0), $sformatf("t6a_k%0d", k));

    // Drop ena at cnt=5: period completes, then idle, then restart
    for (int k = 1; k <= 5; k++) step(1, 1, 0, 0, mk_run(k, 0, 0, 0), $sformatf("t4_k%0d", k));
    for (int k = 6; k <= 15; k++) step(0, 1, 0, 0, mk_run(k, 0, 0, 0), $sformatf("t4_noena_k%0d", k));
    step(0, 1, 0, 0, mk_idle(1, 0), "t4_wrap_idle");
    step(0, 1, 0, 0, mk_idle(0, 0), "t4_idle0");
    step(0, 0, 0, 0, mk_idle(0, 0), "t4_idle1");
    step(1, 1, 0, 0, mk_run(0, 0, 0, 0), "t4_restart");
    for (int k = 1; k <= 3; k++) step(1, 1, 0, 0, mk_run(k, 0, 0, 0), $sformatf("t4_re_k%0d", k));

    // Reset while stretching with timeout set
    for (int k = 4; k <= 8; k++) step(1, 1, 0, 0, mk_run(k, 0, 0, 0), $sformatf("t5_k%0d", k));
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 0, mk_run(8, 1, 0, i == 8), $sformatf("t5_hold%0d", i));
    step(1, 0, 0, 1, mk_idle(0, 0), "t5_rst");

    // Reset and ena together
    step(1, 1, 0, 1, mk_idle(0, 0), "t6b_rst_ena");
    step(1, 1, 0, 0, mk_run(0, 0, 0, 0), "t6b_start");
    step(1, 1, 0, 0, mk_run(1, 0, 0, 0), "t6b_k1");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
